// File: rtl/imm_decode_stage_pkg.sv
// Shared defines for the immediate decode stage: formats, opcodes, RVC fields.
package imm_decode_stage_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_C    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // instr[1:0] quadrant values
  localparam logic [1:0] C_Q1      = 2'b01;
  localparam logic [1:0] C_NOT_RVC = 2'b11;

  // quadrant-1 funct3 (instr[15:13])
  localparam logic [2:0] C3_ADDI = 3'b000;
  localparam logic [2:0] C3_LI   = 3'b010;
  localparam logic [2:0] C3_J    = 3'b101;
  localparam logic [2:0] C3_BEQZ = 3'b110;
  localparam logic [2:0] C3_BNEZ = 3'b111;

endpackage

// File: rtl/imm_decode_stage_core.sv
// Purely combinational immediate/format decode of one instruction word.
module imm_decode_core
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b0
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic signed [5:0]  imm_ci;
  logic signed [11:0] imm_cj;
  logic signed [8:0]  imm_cb;

  assign imm_i  = instr[31:20];
  assign imm_s  = {instr[31:25], instr[11:7]};
  assign imm_b  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_ci = {instr[12], instr[6:2]};
  assign imm_cj = {instr[12], instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
  assign imm_cb = {instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};

  // select format and sign-extended immediate; unrecognised encodings flag illegal
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] != C_NOT_RVC) begin
      if (RVC_EN) begin
        fmt = FMT_C;
        if (instr[1:0] == C_Q1) begin
          case (instr[15:13])
            C3_ADDI, C3_LI:   imm = XLEN'(imm_ci);
            C3_J:             imm = XLEN'(imm_cj);
            C3_BEQZ, C3_BNEZ: imm = XLEN'(imm_cb);
            default:          illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end else begin
        illegal = 1'b1;
      end
    end else begin
      case (instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
          fmt = FMT_I;
          imm = XLEN'(imm_i);
        end
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            fmt = FMT_I;
            imm = XLEN'(imm_i);
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = XLEN'(imm_s);
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          imm = XLEN'(imm_b);
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = XLEN'(imm_u);
        end
        OPC_JAL: begin
          fmt = FMT_J;
          imm = XLEN'(imm_j);
        end
        OPC_OP: begin
          fmt = FMT_NONE;
        end
        OPC_OP_32: begin
          illegal = (XLEN != 64);
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: combinational decode into a main+skid output buffer.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  logic            main_valid, skid_valid;
  logic [XLEN-1:0] main_imm, skid_imm;
  fmt_e            main_fmt, skid_fmt;
  logic            main_illegal, skid_illegal;
  logic [XLEN-1:0] main_pc, skid_pc;

  logic in_fire, out_fire;

  imm_decode_core #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) u_core (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // skid occupancy is a flop, so in_ready is registered and never depends on out_ready
  assign in_ready    = ~skid_valid;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = main_valid & out_ready;

  assign out_valid   = main_valid;
  assign out_imm     = main_imm;
  assign out_fmt     = main_fmt;
  assign out_illegal = main_illegal;
  assign out_pc      = main_pc;

  // main refills from skid first (preserves order), otherwise from the decoder;
  // main is only rewritten when empty or draining, so outputs hold under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid   <= 1'b0;
      main_imm     <= '0;
      main_fmt     <= FMT_NONE;
      main_illegal <= 1'b0;
      main_pc      <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
      skid_pc      <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_valid   <= 1'b1;
        main_imm     <= skid_imm;
        main_fmt     <= skid_fmt;
        main_illegal <= skid_illegal;
        main_pc      <= skid_pc;
        skid_valid   <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_imm     <= dec_imm;
          main_fmt     <= dec_fmt;
          main_illegal <= dec_illegal;
          main_pc      <= in_pc;
        end
      end
    end else if (in_fire) begin
      skid_valid   <= 1'b1;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_illegal <= dec_illegal;
      skid_pc      <= in_pc;
    end
  end

endmodule
